uart_cmd_ctrl: RTL and testbench

Command-frame controller that sits directly behind the UART byte receiver. It consumes received bytes and assembles fixed 5-byte write frames: header, address, data high, data low, checksum. Each valid frame becomes one 16-bit register write over a valid/ready handshake. Inter-byte timeout and checksum errors are reported to the status logic.

---
 rtl/uart_cmd_pkg.sv | 10 +
 rtl/uart_cmd_tmo.sv | 31 +++
 rtl/uart_cmd_ctrl.sv | 126 ++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command-frame controller.
package uart_cmd_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, DH, DL, CHK, WRITE} state_t;

  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;
  localparam logic [7:0] DEF_HDR = 8'h55;

endpackage

// File: rtl/uart_cmd_tmo.sv
// Inter-byte timeout counter: counts while run is high and fires once it has
// seen TIMEOUT_CYC-1 idle cycles since the last clear.
module uart_cmd_tmo #(
  parameter int TIMEOUT_CYC = 25000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  // Held at zero outside the frame-body states so each frame starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr || !run)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  // A byte arriving on the expiry cycle wins, hence the ~clr term.
  assign expire = run && !clr && (cnt == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles 5-byte write frames (HDR, ADDR, DH, DL, CHK) from the UART byte
// receiver and issues each good frame as one 16-bit register write.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] HDR         = DEF_HDR,
  parameter int         TIMEOUT_CYC = 25000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy,
  output logic [7:0]  ovr_cnt
);

  state_t     state;
  logic       rx_done_d;
  logic       byte_stb;
  logic       run;
  logic       expire;
  logic [7:0] sum;

  // rx_done_d resets high so a level already present at reset release is ignored.
  assign byte_stb = rx_done & ~rx_done_d;
  assign run      = (state == ADDR) || (state == DH) || (state == DL) || (state == CHK);

  uart_cmd_tmo #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (byte_stb),
    .run    (run),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rx_done_d <= 1'b1;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      busy      <= 1'b0;
      ovr_cnt   <= '0;
      sum       <= '0;
    end else begin
      rx_done_d <= rx_done;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (byte_stb && rx_data == HDR) begin
            state <= ADDR;
            busy  <= 1'b1;
          end
        end
        ADDR, DH, DL, CHK: begin
          if (byte_stb) begin
            case (state)
              ADDR: begin
                wr_addr <= rx_data;
                sum     <= rx_data;
                state   <= DH;
              end
              DH: begin
                wr_data[15:8] <= rx_data;
                sum           <= sum + rx_data;
                state         <= DL;
              end
              DL: begin
                wr_data[7:0] <= rx_data;
                sum          <= sum + rx_data;
                state        <= CHK;
              end
              default: begin
                if (rx_data == sum) begin
                  wr_valid <= 1'b1;
                  state    <= WRITE;
                end else begin
                  frame_err <= 1'b1;
                  err_code  <= ERR_CHK;
                  busy      <= 1'b0;
                  state     <= IDLE;
                end
              end
            endcase
          end else if (expire) begin
            frame_err <= 1'b1;
            err_code  <= ERR_TMO;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        WRITE: begin
          // Bytes landing here are lost; only the count is kept for status.
          if (byte_stb && ovr_cnt != 8'hFF)
            ovr_cnt <= ovr_cnt + 8'd1;
          if (wr_ready) begin
            wr_valid <= 1'b0;
            frame_ok <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          wr_valid <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: stimulus pushes expected writes/errors,
// a negedge monitor pops them as the DUT reports frame_ok / frame_err.
module tb_uart_cmd_ctrl;
  import uart_cmd_pkg::*;

  localparam int CLK_T = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_ok;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;
  logic [7:0]  ovr_cnt;

  typedef struct {
    logic        is_err;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [1:0]  code;
    int          width;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  time  last_stb_time = 0;
  logic prev_valid = 1'b0;
  logic prev_hs = 1'b0;
  int   vwidth = 0;

  uart_cmd_ctrl #(
    .HDR         (8'h55),
    .TIMEOUT_CYC (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy),
    .ovr_cnt   (ovr_cnt)
  );

  always #(CLK_T/2) clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  task automatic pushWrite(input logic [7:0] a, input logic [15:0] d, input int w);
    exp_t e;
    e.is_err = 1'b0; e.addr = a; e.data = d; e.code = 2'd0; e.width = w;
    sb.push_back(e);
  endtask

  task automatic pushErr(input logic [1:0] c);
    exp_t e;
    e.is_err = 1'b1; e.addr = 8'h0; e.data = 16'h0; e.code = c; e.width = 0;
    sb.push_back(e);
  endtask

  // at_cycle > 0 places the consuming edge exactly at_cycle clocks after the previous one.
  task automatic applyStimulus(input logic [7:0] b, input int at_cycle);
    if (at_cycle > 0) begin
      while ($time < last_stb_time + time'((at_cycle - 1) * CLK_T)) @(posedge clk);
    end else begin
      @(posedge clk);
    end
    #1;
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    last_stb_time = $time;
    repeat (2) @(posedge clk);
    #1 rx_done = 1'b0;
    @(posedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] a, input logic [7:0] dh, input logic [7:0] dl, input logic [7:0] ck);
    applyStimulus(8'h55, 0);
    applyStimulus(a, 0);
    applyStimulus(dh, 0);
    applyStimulus(dl, 0);
    applyStimulus(ck, 0);
  endtask

  always @(negedge clk) begin
    if (wr_valid) begin
      if (!prev_valid) vwidth = 0;
      vwidth++;
      if (sb.size() == 0 || sb[0].is_err) begin
        checkOutput("unexpected_wr_valid", {31'd0, wr_valid}, 32'd0);
      end else begin
        checkOutput("wr_addr", {24'd0, wr_addr}, {24'd0, sb[0].addr});
        checkOutput("wr_data", {16'd0, wr_data}, {16'd0, sb[0].data});
      end
    end
    if (frame_ok) begin
      if (sb.size() == 0 || sb[0].is_err) begin
        checkOutput("unexpected_frame_ok", {31'd0, frame_ok}, 32'd0);
      end else begin
        checkOutput("ok_after_handshake", {31'd0, prev_hs}, 32'd1);
        if (sb[0].width > 0)
          checkOutput("wr_valid_width", vwidth, sb[0].width);
        void'(sb.pop_front());
      end
    end
    if (frame_err) begin
      if (sb.size() == 0 || !sb[0].is_err) begin
        checkOutput("unexpected_frame_err", {31'd0, frame_err}, 32'd0);
      end else begin
        checkOutput("err_code", {30'd0, err_code}, {30'd0, sb[0].code});
        void'(sb.pop_front());
      end
    end
    prev_valid = wr_valid;
    prev_hs    = wr_valid & wr_ready;
  end

  initial begin
    #(CLK_T * 20000);
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic found;

    // rx_done already high when reset releases must not count as a byte.
    rst_n    = 1'b0;
    rx_done  = 1'b1;
    rx_data  = 8'h55;
    wr_ready = 1'b1;
    #23;
    checkOutput("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    checkOutput("rst_wr_data", {16'd0, wr_data}, 32'd0);
    checkOutput("rst_err_code", {30'd0, err_code}, 32'd0);
    checkOutput("rst_ovr_cnt", {24'd0, ovr_cnt}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1 rx_done = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("no_stb_at_reset", {31'd0, busy}, 32'd0);

    pushWrite(8'h12, 16'h3456, 1);
    sendFrame(8'h12, 8'h34, 8'h56, 8'h9C);
    repeat (3) @(posedge clk);

    pushErr(ERR_CHK);
    sendFrame(8'h12, 8'h34, 8'h56, 8'h9D);
    pushWrite(8'h12, 16'h3456, 1);
    sendFrame(8'h12, 8'h34, 8'h56, 8'h9C);
    repeat (3) @(negedge clk);
    checkOutput("err_code_held", {30'd0, err_code}, {30'd0, ERR_CHK});

    applyStimulus(8'h00, 0);
    applyStimulus(8'hAA, 0);
    @(negedge clk);
    checkOutput("noise_ignored", {31'd0, busy}, 32'd0);
    pushWrite(8'h55, 16'h0001, 1);
    sendFrame(8'h55, 8'h00, 8'h01, 8'h56);
    repeat (3) @(posedge clk);

    pushErr(ERR_TMO);
    applyStimulus(8'h55, 0);
    applyStimulus(8'h12, 0);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_err) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("tmo_seen", {31'd0, found}, 32'd1);
    checkOutput("tmo_latency", 32'($time - last_stb_time), 32'(100 * CLK_T + CLK_T / 2));
    @(negedge clk);
    checkOutput("tmo_code", {30'd0, err_code}, {30'd0, ERR_TMO});
    checkOutput("tmo_idle", {31'd0, busy}, 32'd0);

    // Third byte lands on the very cycle the counter would expire.
    pushWrite(8'h12, 16'h3456, 1);
    applyStimulus(8'h55, 0);
    applyStimulus(8'h12, 0);
    applyStimulus(8'h34, 100);
    applyStimulus(8'h56, 0);
    applyStimulus(8'h9C, 0);
    repeat (3) @(posedge clk);

    wr_ready = 1'b0;
    pushWrite(8'hA0, 16'h1234, 0);
    sendFrame(8'hA0, 8'h12, 8'h34, 8'hE6);
    applyStimulus(8'h55, 0);
    applyStimulus(8'h11, 0);
    applyStimulus(8'h22, 0);
    repeat (30) @(posedge clk);
    @(negedge clk);
    checkOutput("ovr_cnt", {24'd0, ovr_cnt}, 32'd3);
    checkOutput("wr_valid_held", {31'd0, wr_valid}, 32'd1);
    @(posedge clk);
    #1 wr_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("write_done_idle", {31'd0, busy}, 32'd0);

    applyStimulus(8'h55, 0);
    applyStimulus(8'h12, 0);
    @(negedge clk);
    checkOutput("busy_mid_frame", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("async_rst_err_code", {30'd0, err_code}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    pushWrite(8'h12, 16'h3456, 1);
    sendFrame(8'h12, 8'h34, 8'h56, 8'h9C);

    repeat (10) @(posedge clk);
    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
